// File: rtl/dmi_buffer_stage_pkg.sv
// DMI payload types shared by the buffer stage and its FIFO.
package dmi_buffer_stage_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  localparam int unsigned DMI_REQ_W  = $bits(dmi_req_t);
  localparam int unsigned DMI_RESP_W = $bits(dmi_resp_t);

endpackage

// File: rtl/dmi_buffer_stage_fifo.sv
// Synchronous FIFO with flush; any depth >= 1, pointers wrap modulo DEPTH.
module dmi_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_o  = (level == LVL_W'(DEPTH));
  assign empty_o = (level == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];
  assign level_o = level;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      // storage is left as is; only the bookkeeping is dropped
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dmi_buffer_stage.sv
// DMI buffer stage: request and response FIFOs with flush; DMI_BUF_STATS_EN adds transfer counters.
module dmi_buffer_stage
  import dmi_buffer_stage_pkg::*;
#(
  parameter int unsigned REQ_DEPTH  = 2,
  parameter int unsigned RESP_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst_i,
  input  logic                              dmi_clear_i,
  input  dmi_req_t                          dmi_req_i,
  input  logic                              dmi_req_valid_i,
  output logic                              dmi_req_ready_o,
  output dmi_resp_t                         dmi_resp_o,
  output logic                              dmi_resp_valid_o,
  input  logic                              dmi_resp_ready_i,
  output logic                              dmi_clear_o,
  output dmi_req_t                          dmi_req_o,
  output logic                              dmi_req_valid_o,
  input  logic                              dmi_req_ready_i,
  input  dmi_resp_t                         dmi_resp_i,
  input  logic                              dmi_resp_valid_i,
  output logic                              dmi_resp_ready_o,
  output logic [$clog2(REQ_DEPTH+1)-1:0]    req_level_o,
  output logic [$clog2(RESP_DEPTH+1)-1:0]   resp_level_o
`ifdef DMI_BUF_STATS_EN
  ,
  output logic [CNT_W-1:0]                  req_xfer_cnt_o,
  output logic [CNT_W-1:0]                  resp_xfer_cnt_o
`endif
);

  logic req_push, req_pop, req_full, req_empty;
  logic resp_push, resp_pop, resp_full, resp_empty;
  logic [DMI_REQ_W-1:0]  req_head;
  logic [DMI_RESP_W-1:0] resp_head;

  // ready depends only on registered occupancy, never on the far side's ready
  assign dmi_req_ready_o  = !rst_i && !req_full && !dmi_clear_i;
  assign dmi_resp_ready_o = !rst_i && !resp_full && !dmi_clear_i;

  assign req_push  = dmi_req_valid_i && dmi_req_ready_o;
  assign req_pop   = dmi_req_valid_o && dmi_req_ready_i;
  assign resp_push = dmi_resp_valid_i && dmi_resp_ready_o;
  assign resp_pop  = dmi_resp_valid_o && dmi_resp_ready_i;

  assign dmi_req_valid_o  = !req_empty;
  assign dmi_resp_valid_o = !resp_empty;
  assign dmi_req_o        = dmi_req_t'(req_head);
  assign dmi_resp_o       = dmi_resp_t'(resp_head);

  dmi_fifo #(
    .WIDTH (DMI_REQ_W),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .flush_i (dmi_clear_i),
    .push_i  (req_push),
    .data_i  (DMI_REQ_W'(dmi_req_i)),
    .pop_i   (req_pop),
    .data_o  (req_head),
    .level_o (req_level_o),
    .full_o  (req_full),
    .empty_o (req_empty)
  );

  dmi_fifo #(
    .WIDTH (DMI_RESP_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .flush_i (dmi_clear_i),
    .push_i  (resp_push),
    .data_i  (DMI_RESP_W'(dmi_resp_i)),
    .pop_i   (resp_pop),
    .data_o  (resp_head),
    .level_o (resp_level_o),
    .full_o  (resp_full),
    .empty_o (resp_empty)
  );

  always_ff @(posedge clk) begin
    if (rst_i) dmi_clear_o <= 1'b0;
    else       dmi_clear_o <= dmi_clear_i;
  end

`ifdef DMI_BUF_STATS_EN
  // a pop coinciding with a clear is discarded, so it is not counted either
  always_ff @(posedge clk) begin
    if (rst_i) begin
      req_xfer_cnt_o  <= '0;
      resp_xfer_cnt_o <= '0;
    end else if (!dmi_clear_i) begin
      if (req_pop)  req_xfer_cnt_o  <= req_xfer_cnt_o + CNT_W'(1);
      if (resp_pop) resp_xfer_cnt_o <= resp_xfer_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dmi_buffer_stage.sv
// Bench for dmi_buffer_stage: queue-based reference model, directed scenarios, random traffic.
module tb_dmi_buffer_stage;
  import dmi_buffer_stage_pkg::*;

  localparam int unsigned REQ_DEPTH  = 3;
  localparam int unsigned RESP_DEPTH = 2;
  localparam int unsigned CNT_W      = 16;

  logic      clk = 1'b0;
  logic      rst_i;
  logic      dmi_clear_i;
  dmi_req_t  dmi_req_i;
  logic      dmi_req_valid_i;
  logic      dmi_req_ready_o;
  dmi_resp_t dmi_resp_o;
  logic      dmi_resp_valid_o;
  logic      dmi_resp_ready_i;
  logic      dmi_clear_o;
  dmi_req_t  dmi_req_o;
  logic      dmi_req_valid_o;
  logic      dmi_req_ready_i;
  dmi_resp_t dmi_resp_i;
  logic      dmi_resp_valid_i;
  logic      dmi_resp_ready_o;
  logic [$clog2(REQ_DEPTH+1)-1:0]  req_level_o;
  logic [$clog2(RESP_DEPTH+1)-1:0] resp_level_o;
`ifdef DMI_BUF_STATS_EN
  logic [CNT_W-1:0] req_xfer_cnt_o;
  logic [CNT_W-1:0] resp_xfer_cnt_o;
`endif

  always #5 clk = ~clk;

  dmi_buffer_stage #(
    .REQ_DEPTH  (REQ_DEPTH),
    .RESP_DEPTH (RESP_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .dmi_clear_i      (dmi_clear_i),
    .dmi_req_i        (dmi_req_i),
    .dmi_req_valid_i  (dmi_req_valid_i),
    .dmi_req_ready_o  (dmi_req_ready_o),
    .dmi_resp_o       (dmi_resp_o),
    .dmi_resp_valid_o (dmi_resp_valid_o),
    .dmi_resp_ready_i (dmi_resp_ready_i),
    .dmi_clear_o      (dmi_clear_o),
    .dmi_req_o        (dmi_req_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_resp_i       (dmi_resp_i),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .req_level_o      (req_level_o),
    .resp_level_o     (resp_level_o)
`ifdef DMI_BUF_STATS_EN
    ,
    .req_xfer_cnt_o   (req_xfer_cnt_o),
    .resp_xfer_cnt_o  (resp_xfer_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues updated at each rising edge.
  dmi_req_t        req_q[$];
  dmi_resp_t       resp_q[$];
  bit              model_ok = 0;
  bit              clear_exp = 0;
  logic [CNT_W-1:0] req_cnt_exp = '0;
  logic [CNT_W-1:0] resp_cnt_exp = '0;

  always @(posedge clk) begin
    bit req_pop, req_push, resp_pop, resp_push;
    if (rst_i) begin
      req_q.delete();
      resp_q.delete();
      clear_exp    = 0;
      req_cnt_exp  = '0;
      resp_cnt_exp = '0;
      model_ok     = 1;
    end else if (model_ok) begin
      clear_exp = dmi_clear_i;
      if (dmi_clear_i) begin
        req_q.delete();
        resp_q.delete();
      end else begin
        req_pop   = (req_q.size() > 0) && dmi_req_ready_i;
        req_push  = dmi_req_valid_i && (req_q.size() < REQ_DEPTH);
        resp_pop  = (resp_q.size() > 0) && dmi_resp_ready_i;
        resp_push = dmi_resp_valid_i && (resp_q.size() < RESP_DEPTH);
        if (req_pop)  begin void'(req_q.pop_front());  req_cnt_exp++;  end
        if (resp_pop) begin void'(resp_q.pop_front()); resp_cnt_exp++; end
        if (req_push)  req_q.push_back(dmi_req_i);
        if (resp_push) resp_q.push_back(dmi_resp_i);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("req_valid", 64'(dmi_req_valid_o), 64'(req_q.size() != 0));
      check("resp_valid", 64'(dmi_resp_valid_o), 64'(resp_q.size() != 0));
      check("req_level", 64'(req_level_o), 64'(req_q.size()));
      check("resp_level", 64'(resp_level_o), 64'(resp_q.size()));
      check("req_ready", 64'(dmi_req_ready_o),
            64'(!rst_i && !dmi_clear_i && req_q.size() < REQ_DEPTH));
      check("resp_ready", 64'(dmi_resp_ready_o),
            64'(!rst_i && !dmi_clear_i && resp_q.size() < RESP_DEPTH));
      check("clear_o", 64'(dmi_clear_o), 64'(clear_exp));
      if (req_q.size() != 0)  check("req_head", 64'(dmi_req_o), 64'(req_q[0]));
      if (resp_q.size() != 0) check("resp_head", 64'(dmi_resp_o), 64'(resp_q[0]));
`ifdef DMI_BUF_STATS_EN
      check("req_cnt", 64'(req_xfer_cnt_o), 64'(req_cnt_exp));
      check("resp_cnt", 64'(resp_xfer_cnt_o), 64'(resp_cnt_exp));
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic dmi_req_t mk_req(input int addr);
    dmi_req_t r;
    r.addr = 7'(addr);
    r.op   = DTM_READ;
    r.data = 32'(addr) * 32'h0101_0101;
    return r;
  endfunction

  function automatic dmi_resp_t mk_resp(input int v);
    dmi_resp_t r;
    r.data = 32'(v) ^ 32'hA5A5_0000;
    r.resp = 2'(v);
    return r;
  endfunction

  initial begin
    int pops;
    int xfers;
    int cyc;
`ifdef DMI_BUF_STATS_EN
    logic [CNT_W-1:0] cnt_before;
`endif
    rst_i = 1; dmi_clear_i = 0;
    dmi_req_i = '0; dmi_req_valid_i = 0; dmi_req_ready_i = 0;
    dmi_resp_i = '0; dmi_resp_valid_i = 0; dmi_resp_ready_i = 0;

    // reset held two cycles
    tick();
    @(negedge clk);
    check("rst_req_ready", 64'(dmi_req_ready_o), 64'd0);
    check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
    check("rst_req_level", 64'(req_level_o), 64'd0);
    check("rst_valid", 64'({dmi_req_valid_o, dmi_resp_valid_o, dmi_clear_o}), 64'd0);
    tick();
    rst_i = 0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(dmi_req_ready_o), 64'd1);
    check("post_rst_resp_ready", 64'(dmi_resp_ready_o), 64'd1);

    // fill request FIFO with DM stalled
    for (int i = 0; i < 4; i++) begin
      tick();
      dmi_req_i = mk_req(8'h10 + i);
      dmi_req_valid_i = 1;
      @(negedge clk);
      check("fill_ready", 64'(dmi_req_ready_o), 64'(i < 3));
    end
    tick();
    dmi_req_valid_i = 0;
    @(negedge clk);
    check("fill_level", 64'(req_level_o), 64'd3);
    tick();
    dmi_req_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drain_addr", 64'(dmi_req_o.addr), 64'(8'h10 + i));
      tick();
    end
    @(negedge clk);
    check("drain_empty", 64'(dmi_req_valid_o), 64'd0);

    // streaming
    xfers = 0;
    for (int i = 0; i < 20; i++) begin
      dmi_req_i = mk_req(8'h50 + i);
      dmi_req_valid_i = 1;
      @(negedge clk);
      if (i > 0) check("stream_level", 64'(req_level_o), 64'd1);
      tick();
    end
    dmi_req_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dmi_req_valid_o && dmi_req_ready_i) xfers++;
      tick();
    end
    check("stream_tail", 64'(xfers), 64'd1);
    dmi_req_ready_i = 0;

    // response full with same-cycle pop
    dmi_resp_ready_i = 0;
    dmi_resp_valid_i = 1;
    dmi_resp_i = mk_resp(8'hA0);
    tick();
    dmi_resp_i = mk_resp(8'hA1);
    tick();
    dmi_resp_i = mk_resp(8'hA2);
    @(negedge clk);
    check("resp_full_level", 64'(resp_level_o), 64'd2);
    tick();
    dmi_resp_ready_i = 1;
    @(negedge clk);
    check("resp_full_nopass", 64'(dmi_resp_ready_o), 64'd0);
    tick();
    dmi_resp_valid_i = 0;
    @(negedge clk);
    check("resp_after_pop_level", 64'(resp_level_o), 64'd1);
    check("resp_after_pop_ready", 64'(dmi_resp_ready_o), 64'd1);
    check("resp_head_a1", 64'(dmi_resp_o.data), 64'(32'hA1 ^ 32'hA5A5_0000));
    tick(2);
    dmi_resp_ready_i = 0;

    // clear with a push in the same cycle
    dmi_req_valid_i = 1;
    dmi_req_i = mk_req(8'h30);
    tick();
    dmi_req_i = mk_req(8'h31);
    tick();
    dmi_req_i = mk_req(8'h20);
    dmi_clear_i = 1;
    @(negedge clk);
    check("clear_ready", 64'(dmi_req_ready_o), 64'd0);
    tick();
    dmi_clear_i = 0;
    dmi_req_valid_i = 0;
    @(negedge clk);
    check("clear_level", 64'(req_level_o), 64'd0);
    check("clear_o_high", 64'(dmi_clear_o), 64'd1);
    check("clear_dropped", 64'(dmi_req_valid_o), 64'd0);
    tick();
    @(negedge clk);
    check("clear_o_low", 64'(dmi_clear_o), 64'd0);

    // mixed push/pop across the depth-3 wrap
`ifdef DMI_BUF_STATS_EN
    cnt_before = req_xfer_cnt_o;
`endif
    pops = 0;
    cyc = 0;
    while (pops < 10 && cyc < 200) begin
      tick();
      dmi_req_i = mk_req(8'h40 + cyc);
      dmi_req_valid_i = 1;
      dmi_req_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (dmi_req_valid_o && dmi_req_ready_i) pops++;
      cyc++;
    end
    check("wrap_pops_done", 64'(pops), 64'd10);
    tick();
    dmi_req_valid_i = 0;
    dmi_req_ready_i = 0;
`ifdef DMI_BUF_STATS_EN
    @(negedge clk);
    check("wrap_cnt_delta", 64'(CNT_W'(req_xfer_cnt_o - cnt_before)), 64'd10);
`endif

    // random traffic with occasional clear and reset
    for (int i = 0; i < 800; i++) begin
      tick();
      rst_i            = ($urandom_range(0, 199) == 0);
      dmi_clear_i      = ($urandom_range(0, 24) == 0);
      dmi_req_valid_i  = 1'($urandom_range(0, 1));
      dmi_req_ready_i  = ($urandom_range(0, 2) != 0);
      dmi_resp_valid_i = 1'($urandom_range(0, 1));
      dmi_resp_ready_i = ($urandom_range(0, 2) != 0);
      dmi_req_i.addr   = 7'($urandom);
      dmi_req_i.op     = dtm_op_e'(2'($urandom_range(0, 2)));
      dmi_req_i.data   = $urandom;
      dmi_resp_i.data  = $urandom;
      dmi_resp_i.resp  = 2'($urandom);
    end
    tick();
    rst_i = 0; dmi_clear_i = 0;
    dmi_req_valid_i = 0; dmi_resp_valid_i = 0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
